// File: rtl/audio_fir_pkg.sv
// Shared types and width helpers for the multichannel audio FIR.
package audio_fir_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MAC   = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_e;

    // Register stages between the last tap issue and the final accumulator update
    localparam int MAC_DRAIN = 3;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int chan_width(input int num_channels);
        return (num_channels > 1) ? clog2_f(num_channels) : 1;
    endfunction

    function automatic int acc_width(input int data_w, input int coeff_w, input int num_taps);
        return data_w + coeff_w + clog2_f(num_taps);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic shift and saturation of the FIR accumulator.
module fir_round_sat #(
    parameter int ACC_W      = 48,
    parameter int DATA_WIDTH = 24,
    parameter int OUT_SHIFT  = 17
) (
    input  logic signed [ACC_W-1:0]      acc,
    output logic signed [DATA_WIDTH-1:0] data
);

    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] HALF    = EXT_W'(1) << (OUT_SHIFT - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        biased  = {acc[ACC_W-1], acc} + HALF;
        shifted = biased >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            data = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            data = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/audio_fir_mc.sv
// Time-multiplexed multichannel FIR: one shared coefficient set, per-channel history rings.
//
// state | meaning
// CLEAR | zero history and coefficient RAMs, one address per cycle
// IDLE  | accept a sample and/or a coefficient write
// MAC   | issue one tap per cycle, then drain the read/multiply/accumulate pipe
// OUT   | hold result until m_ready, then advance the channel write pointer
module audio_fir_mc
    import audio_fir_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int COEFF_WIDTH  = 18,
    parameter int NUM_TAPS     = 64,
    parameter int NUM_CHANNELS = 2,
    parameter int OUT_SHIFT    = 17,
    localparam int CW = chan_width(NUM_CHANNELS),
    localparam int AW = clog2_f(NUM_TAPS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [DATA_WIDTH-1:0]  s_data,
    input  logic [CW-1:0]                 s_chan,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          coef_wr_en,
    input  logic [AW-1:0]                 coef_wr_addr,
    input  logic signed [COEFF_WIDTH-1:0] coef_wr_data,
    output logic signed [DATA_WIDTH-1:0]  m_data,
    output logic [CW-1:0]                 m_chan,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          busy
);

    localparam int HDEPTH = NUM_CHANNELS * NUM_TAPS;
    localparam int HW     = clog2_f(HDEPTH);
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int MCW    = clog2_f(NUM_TAPS + MAC_DRAIN + 2);
    localparam logic [MCW-1:0] MAC_LOAD  = MCW'(NUM_TAPS + MAC_DRAIN);
    localparam logic [MCW-1:0] ISSUE_MIN = MCW'(MAC_DRAIN + 1);

    fir_state_e state_q, state_d;

    logic [HW-1:0]  clr_cnt_q;
    logic [MCW-1:0] mac_cnt_q;
    logic [AW-1:0]  tap_q;
    logic [AW-1:0]  base_q;
    logic [CW-1:0]  chan_q;
    logic [AW-1:0]  wptr_q [NUM_CHANNELS];

    logic signed [DATA_WIDTH-1:0]  hist_mem [HDEPTH];
    logic signed [COEFF_WIDTH-1:0] coef_mem [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]  hist_rd_q;
    logic signed [COEFF_WIDTH-1:0] coef_rd_q;
    logic signed [PROD_W-1:0]      prod_q;
    logic signed [ACC_W-1:0]       acc_q;
    logic signed [DATA_WIDTH-1:0]  rnd_data;
    logic                          rd_vld_q;
    logic                          mul_vld_q;

    logic                          chan_ok;
    logic                          start;
    logic                          issue;
    logic                          hist_we;
    logic [HW-1:0]                 hist_waddr;
    logic signed [DATA_WIDTH-1:0]  hist_wdata;
    logic [HW-1:0]                 hist_raddr;
    logic                          coef_we;
    logic [AW-1:0]                 coef_waddr;
    logic signed [COEFF_WIDTH-1:0] coef_wdata;

    function automatic logic [HW-1:0] hist_idx(input logic [CW-1:0] ch, input logic [AW-1:0] ptr);
        return HW'(int'(ch) * NUM_TAPS + int'(ptr));
    endfunction

    assign s_ready = (state_q == ST_IDLE);
    assign busy    = (state_q != ST_IDLE);
    assign chan_ok = (32'(s_chan) < NUM_CHANNELS);
    assign start   = s_ready && s_valid && chan_ok;
    assign issue   = (state_q == ST_MAC) && (mac_cnt_q >= ISSUE_MIN);

    always_comb begin
        hist_we    = 1'b0;
        hist_waddr = hist_idx(s_chan, wptr_q[s_chan]);
        hist_wdata = s_data;
        coef_we    = 1'b0;
        coef_waddr = coef_wr_addr;
        coef_wdata = coef_wr_data;
        if (state_q == ST_CLEAR) begin
            hist_we    = 1'b1;
            hist_waddr = clr_cnt_q;
            hist_wdata = '0;
            coef_we    = 1'b1;
            coef_waddr = clr_cnt_q[AW-1:0];
            coef_wdata = '0;
        end else if (state_q == ST_IDLE) begin
            hist_we = start;
            coef_we = coef_wr_en;
        end
    end

    // Tap k reads x[n-k]; the AW-bit subtraction wraps modulo NUM_TAPS.
    assign hist_raddr = hist_idx(chan_q, base_q - tap_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt_q == '0) state_d = ST_IDLE;
            ST_IDLE:  if (start) state_d = ST_MAC;
            ST_MAC:   if (mac_cnt_q == '0) state_d = ST_OUT;
            ST_OUT:   if (m_ready) state_d = ST_IDLE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= HW'(HDEPTH - 1);
            mac_cnt_q <= '0;
            tap_q     <= '0;
            base_q    <= '0;
            chan_q    <= '0;
            rd_vld_q  <= 1'b0;
            mul_vld_q <= 1'b0;
            acc_q     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_chan    <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) wptr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rd_vld_q  <= issue;
            mul_vld_q <= rd_vld_q;
            if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q - 1'b1;

            if (start) begin
                mac_cnt_q <= MAC_LOAD;
                tap_q     <= '0;
                base_q    <= wptr_q[s_chan];
                chan_q    <= s_chan;
                acc_q     <= '0;
            end else if (state_q == ST_MAC) begin
                if (mac_cnt_q != '0) mac_cnt_q <= mac_cnt_q - 1'b1;
                if (issue) tap_q <= tap_q + 1'b1;
                if (mul_vld_q) acc_q <= acc_q + ACC_W'(prod_q);
            end

            if ((state_q == ST_MAC) && (mac_cnt_q == '0)) begin
                m_valid <= 1'b1;
                m_data  <= rnd_data;
                m_chan  <= chan_q;
            end else if ((state_q == ST_OUT) && m_ready) begin
                m_valid        <= 1'b0;
                wptr_q[chan_q] <= wptr_q[chan_q] + 1'b1;
            end
        end
    end

    // RAM ports and multiply stage carry no reset; the valid flags gate their use.
    always_ff @(posedge clk) begin
        if (hist_we) hist_mem[hist_waddr] <= hist_wdata;
        if (coef_we) coef_mem[coef_waddr] <= coef_wdata;
        hist_rd_q <= hist_mem[hist_raddr];
        coef_rd_q <= coef_mem[tap_q];
        if (rd_vld_q) prod_q <= hist_rd_q * coef_rd_q;
    end

    fir_round_sat #(
        .ACC_W      (ACC_W),
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_SHIFT  (OUT_SHIFT)
    ) u_round_sat (
        .acc  (acc_q),
        .data (rnd_data)
    );

endmodule
